// File: rtl/core_pkg.sv
// Shared address-map constants and fetch-sequencer state encoding for the
// embedded RISC core front end.
package core_pkg;
  localparam int unsigned ADDR_WIDTH = 24;
  localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 24'h000000;
  localparam logic [ADDR_WIDTH-1:0] INT_VECTOR   = 24'h000010;
  localparam int unsigned INC_STEP = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority selector: branch (live or pending) over interrupt over
// sequential increment.
module pc_next_sel #(
  parameter int unsigned AddrWidth = 24,
  parameter logic [AddrWidth-1:0] IntVector = 24'h000010,
  parameter int unsigned IncStep = 1
) (
  input  logic [AddrWidth-1:0] pc,
  input  logic                 branch_valid,
  input  logic [AddrWidth-1:0] branch_target,
  input  logic                 pend_valid,
  input  logic [AddrWidth-1:0] pend_target,
  input  logic                 int_req,
  input  logic                 int_en,
  output logic [AddrWidth-1:0] next_pc,
  output logic [AddrWidth-1:0] pc_inc,
  output logic                 take_int
);
  always_comb begin
    pc_inc   = pc + AddrWidth'(IncStep);
    take_int = 1'b0;
    next_pc  = pc_inc;
    // A live strobe is newer than anything pending, so it wins
    if (branch_valid) begin
      next_pc = branch_target;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end else if (int_req && int_en) begin
      next_pc  = IntVector;
      take_int = 1'b1;
    end
  end
endmodule

// File: rtl/pc_fetch_gen.sv
// Program counter and instruction-fetch address generator with req/ready
// handshake, branch/interrupt redirect and stall hold.
module pc_fetch_gen
  import core_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_WIDTH,
  parameter logic [AddrWidth-1:0] ResetVector = AddrWidth'(RESET_VECTOR),
  parameter logic [AddrWidth-1:0] IntVector   = AddrWidth'(INT_VECTOR),
  parameter int unsigned IncStep = INC_STEP
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_valid,
  input  logic [AddrWidth-1:0] branch_target,
  input  logic                 int_req,
  input  logic                 int_en,
  input  logic                 mem_ready,
  output logic                 fetch_req,
  output logic [AddrWidth-1:0] pc_out,
  output logic                 fetch_done,
  output logic                 int_ack,
  output logic [AddrWidth-1:0] epc_out
);
  fetch_state_e         r_state;
  logic [AddrWidth-1:0] r_pc;
  logic [AddrWidth-1:0] r_epc;
  logic [AddrWidth-1:0] r_pend_target;
  logic                 r_pend_valid;
  logic                 r_fetch_done;
  logic                 r_int_ack;

  logic                 w_accept;
  logic                 w_advance;
  logic                 w_take_int;
  logic [AddrWidth-1:0] w_next_pc;
  logic [AddrWidth-1:0] w_pc_inc;

  always_comb begin
    w_accept  = (r_state == S_FETCH) && mem_ready;
    w_advance = (w_accept && !stall) || ((r_state == S_HOLD) && !stall);
  end

  pc_next_sel #(
    .AddrWidth (AddrWidth),
    .IntVector (IntVector),
    .IncStep   (IncStep)
  ) u_next_sel (
    .pc            (r_pc),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .pend_valid    (r_pend_valid),
    .pend_target   (r_pend_target),
    .int_req       (int_req),
    .int_en        (int_en),
    .next_pc       (w_next_pc),
    .pc_inc        (w_pc_inc),
    .take_int      (w_take_int)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_pc          <= ResetVector;
      r_epc         <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_fetch_done  <= 1'b0;
      r_int_ack     <= 1'b0;
    end else begin
      r_fetch_done <= w_accept;
      r_int_ack    <= w_advance && w_take_int;
      // Branches seen outside an advance are parked until the next one
      if (w_advance) begin
        r_pc         <= w_next_pc;
        r_pend_valid <= 1'b0;
        if (w_take_int) r_epc <= w_pc_inc;
      end else if (branch_valid) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= branch_target;
      end
      case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: if (mem_ready && stall) r_state <= S_HOLD;
        S_HOLD:  if (!stall) r_state <= S_FETCH;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fetch_req  = (r_state == S_FETCH);
  assign pc_out     = r_pc;
  assign fetch_done = r_fetch_done;
  assign int_ack    = r_int_ack;
  assign epc_out    = r_epc;
endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed, table-driven bench for pc_fetch_gen with hand-computed expectations.
module tb_pc_fetch_gen;
  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_valid;
  logic [23:0] branch_target;
  logic        int_req;
  logic        int_en;
  logic        mem_ready;
  logic        fetch_req;
  logic [23:0] pc_out;
  logic        fetch_done;
  logic        int_ack;
  logic [23:0] epc_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clock = ~clock;

  pc_fetch_gen dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .int_req       (int_req),
    .int_en        (int_en),
    .mem_ready     (mem_ready),
    .fetch_req     (fetch_req),
    .pc_out        (pc_out),
    .fetch_done    (fetch_done),
    .int_ack       (int_ack),
    .epc_out       (epc_out)
  );

  typedef struct {
    logic        rst_n;
    logic        stl;
    logic        bv;
    logic [23:0] bt;
    logic        ir;
    logic        ie;
    logic        mr;
    logic        e_fr;
    logic [23:0] e_pc;
    logic        e_fd;
    logic        e_ia;
    logic [23:0] e_epc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic stl, logic bv, logic [23:0] bt,
                              logic ir, logic ie, logic mr, logic e_fr,
                              logic [23:0] e_pc, logic e_fd, logic e_ia,
                              logic [23:0] e_epc);
    vec_t v;
    v.rst_n = rst_n; v.stl = stl; v.bv = bv; v.bt = bt; v.ir = ir; v.ie = ie;
    v.mr = mr; v.e_fr = e_fr; v.e_pc = e_pc; v.e_fd = e_fd; v.e_ia = e_ia;
    v.e_epc = e_epc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [23:0] act,
                     input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    reset = v.rst_n; stall = v.stl; branch_valid = v.bv; branch_target = v.bt;
    int_req = v.ir; int_en = v.ie; mem_ready = v.mr;
    @(posedge clock);
    #1;
    chk("fetch_req",  idx, {23'd0, fetch_req},  {23'd0, v.e_fr});
    chk("pc_out",     idx, pc_out,               v.e_pc);
    chk("fetch_done", idx, {23'd0, fetch_done}, {23'd0, v.e_fd});
    chk("int_ack",    idx, {23'd0, int_ack},    {23'd0, v.e_ia});
    chk("epc_out",    idx, epc_out,              v.e_epc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
    int_req = 1'b0; int_en = 1'b0; mem_ready = 1'b0;

    //                rst stl bv bt          ir ie mr  fr pc          fd ia epc
    vecs.push_back(mk(0, 0, 0, 24'h000000, 0, 0, 0,  0, 24'h000000, 0, 0, 24'h000000)); // 0 reset
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 1,  1, 24'h000000, 0, 0, 24'h000000)); // 1 idle->fetch
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 1,  1, 24'h000001, 1, 0, 24'h000000));
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 1,  1, 24'h000002, 1, 0, 24'h000000));
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 1,  1, 24'h000003, 1, 0, 24'h000000));
    vecs.push_back(mk(1, 0, 1, 24'hFFFFFE, 0, 0, 1,  1, 24'hFFFFFE, 1, 0, 24'h000000)); // 5 preload
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 1,  1, 24'hFFFFFF, 1, 0, 24'h000000));
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 1,  1, 24'h000000, 1, 0, 24'h000000)); // wrap
    vecs.push_back(mk(1, 0, 1, 24'h000020, 0, 0, 1,  1, 24'h000020, 1, 0, 24'h000000));
    vecs.push_back(mk(1, 0, 0, 24'h000000, 1, 1, 1,  1, 24'h000010, 1, 1, 24'h000021)); // 9 int taken
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 1, 1,  1, 24'h000011, 1, 0, 24'h000021));
    vecs.push_back(mk(1, 0, 0, 24'h000000, 1, 0, 1,  1, 24'h000012, 1, 0, 24'h000021)); // masked
    vecs.push_back(mk(1, 0, 1, 24'h000400, 1, 1, 1,  1, 24'h000400, 1, 0, 24'h000021)); // branch wins
    vecs.push_back(mk(1, 0, 0, 24'h000000, 1, 1, 1,  1, 24'h000010, 1, 1, 24'h000401));
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 1, 1,  1, 24'h000011, 1, 0, 24'h000401));
    vecs.push_back(mk(1, 0, 1, 24'h001000, 0, 0, 0,  1, 24'h000011, 0, 0, 24'h000401)); // 15 wait+branch
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 0,  1, 24'h000011, 0, 0, 24'h000401));
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 0,  1, 24'h000011, 0, 0, 24'h000401));
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 1,  1, 24'h001000, 1, 0, 24'h000401));
    vecs.push_back(mk(1, 0, 1, 24'h000005, 0, 0, 1,  1, 24'h000005, 1, 0, 24'h000401)); // 19
    vecs.push_back(mk(1, 1, 0, 24'h000000, 0, 0, 1,  0, 24'h000005, 1, 0, 24'h000401)); // ->hold
    vecs.push_back(mk(1, 1, 0, 24'h000000, 0, 0, 1,  0, 24'h000005, 0, 0, 24'h000401));
    vecs.push_back(mk(1, 1, 0, 24'h000000, 0, 0, 1,  0, 24'h000005, 0, 0, 24'h000401));
    vecs.push_back(mk(1, 1, 0, 24'h000000, 0, 0, 1,  0, 24'h000005, 0, 0, 24'h000401));
    vecs.push_back(mk(0, 1, 0, 24'h000000, 0, 0, 1,  0, 24'h000000, 0, 0, 24'h000000)); // 24 reset in hold
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 1,  1, 24'h000000, 0, 0, 24'h000000));
    vecs.push_back(mk(1, 1, 0, 24'h000000, 0, 0, 1,  0, 24'h000000, 1, 0, 24'h000000)); // ->hold
    vecs.push_back(mk(1, 1, 1, 24'h000300, 0, 0, 0,  0, 24'h000000, 0, 0, 24'h000000));
    vecs.push_back(mk(1, 1, 1, 24'h000350, 0, 0, 0,  0, 24'h000000, 0, 0, 24'h000000)); // last wins
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 0,  1, 24'h000350, 0, 0, 24'h000000)); // hold release
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 1,  1, 24'h000351, 1, 0, 24'h000000));
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 1,  1, 24'h000352, 1, 0, 24'h000000)); // pending cleared
    vecs.push_back(mk(0, 0, 0, 24'h000000, 0, 0, 0,  0, 24'h000000, 0, 0, 24'h000000)); // 32
    vecs.push_back(mk(1, 0, 1, 24'h000777, 0, 0, 1,  1, 24'h000000, 0, 0, 24'h000000)); // branch in idle
    vecs.push_back(mk(1, 0, 0, 24'h000000, 0, 0, 1,  1, 24'h000777, 1, 0, 24'h000000));

    foreach (vecs[i]) apply(vecs[i], i);

    // Long memory wait: PC frozen, no done pulse; then a single done pulse.
    for (int k = 0; k < 6; k++)
      apply(mk(1, 0, 0, 24'h0, 0, 0, 0, 1, 24'h000777, 0, 0, 24'h0), 100 + k);
    apply(mk(1, 0, 0, 24'h0, 0, 0, 1, 1, 24'h000778, 1, 0, 24'h0), 110);
    apply(mk(1, 0, 0, 24'h0, 0, 0, 0, 1, 24'h000778, 0, 0, 24'h0), 111);

    // Held interrupt is retaken at every advance until int_req drops.
    apply(mk(1, 0, 0, 24'h0, 1, 1, 1, 1, 24'h000010, 1, 1, 24'h000779), 120);
    apply(mk(1, 0, 0, 24'h0, 1, 1, 1, 1, 24'h000010, 1, 1, 24'h000011), 121);
    apply(mk(1, 0, 0, 24'h0, 0, 1, 1, 1, 24'h000011, 1, 0, 24'h000011), 122);

    // Bounded wait for the first fetch_req after a reset pulse.
    apply(mk(0, 0, 0, 24'h0, 0, 0, 1, 0, 24'h000000, 0, 0, 24'h0), 130);
    @(negedge clock);
    reset = 1'b1;
    cyc = 0;
    while (!fetch_req && cyc < 10) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk("first_fetch_latency", 131, 24'(cyc), 24'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
